// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, operand selects and the
// decoded-instruction record passed from the decoder to the ID/EX stage.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_SHAMT, B_FOUR} b_sel_e;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;
    a_sel_e      a_sel;
    b_sel_e      b_sel;
    logic        rd_wen;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
    logic        rs1_used;
    logic        rs2_used;
  } decode_t;

  // Sign-extended immediate for the given instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h000};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I decoder: ALU code, immediate, operand selects,
// class flags and register-usage hints for the load-use detector.
module rv32_decoder
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       writes_rd;
  imm_fmt_e   fmt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Opcode decode; unknown opcodes fall through as illegal with everything else quiet.
  always_comb begin
    dec           = '0;
    dec.a_sel     = A_ZERO;
    dec.b_sel     = B_IMM;
    dec.alu_ctrl  = ALU_ADD;
    dec.rs1_used  = 1'b1;
    writes_rd     = 1'b0;
    fmt           = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        dec.a_sel    = A_RS1;
        dec.b_sel    = B_RS2;
        dec.alu_ctrl = {instr[30] & ((funct3 == 3'b000) | (funct3 == 3'b101)), funct3};
        dec.rs2_used = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt          = IMM_I;
        dec.a_sel    = A_RS1;
        // Shifts only take the low five immediate bits as the shift amount.
        dec.b_sel    = ((funct3 == 3'b001) | (funct3 == 3'b101)) ? B_SHAMT : B_IMM;
        dec.alu_ctrl = {instr[30] & (funct3 == 3'b101), funct3};
        writes_rd    = 1'b1;
      end
      OPC_LUI: begin
        fmt          = IMM_U;
        dec.rs1_used = 1'b0;
        writes_rd    = 1'b1;
      end
      OPC_AUIPC: begin
        fmt          = IMM_U;
        dec.a_sel    = A_PC;
        dec.rs1_used = 1'b0;
        writes_rd    = 1'b1;
      end
      OPC_JAL: begin
        fmt          = IMM_J;
        dec.a_sel    = A_PC;
        dec.b_sel    = B_FOUR;
        dec.is_jump  = 1'b1;
        dec.rs1_used = 1'b0;
        writes_rd    = 1'b1;
      end
      OPC_JALR: begin
        fmt          = IMM_I;
        dec.a_sel    = A_PC;
        dec.b_sel    = B_FOUR;
        dec.is_jump  = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_LOAD: begin
        fmt          = IMM_I;
        dec.a_sel    = A_RS1;
        dec.is_load  = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_STORE: begin
        fmt          = IMM_S;
        dec.a_sel    = A_RS1;
        dec.is_store = 1'b1;
        dec.rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        fmt           = IMM_B;
        dec.a_sel     = A_RS1;
        dec.b_sel     = B_RS2;
        dec.alu_ctrl  = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.rs2_used  = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm    = imm_gen(instr, fmt);
    dec.rd_wen = writes_rd & (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes, forwards operands, detects load-use hazards
// and registers everything the ALU and later stages need.
// Handshake: the decode slot is consumed on a rising edge when valid_w_i_h=1,
// stall_w_i_h=0, flush_w_i_h=0 and hazard_stall_w_o_h=0; while
// hazard_stall_w_o_h or stall_w_i_h is high, upstream must hold its slot.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_h,
  input  logic            valid_w_i_h,
  input  logic [31:0]     instr_w_i,
  input  logic [XLEN-1:0] pc_w_i,
  input  logic [XLEN-1:0] rs1_data_w_i,
  input  logic [XLEN-1:0] rs2_data_w_i,
  input  logic [4:0]      exmem_rd_w_i,
  input  logic            exmem_wen_w_i_h,
  input  logic [XLEN-1:0] exmem_data_w_i,
  input  logic [4:0]      memwb_rd_w_i,
  input  logic            memwb_wen_w_i_h,
  input  logic [XLEN-1:0] memwb_data_w_i,
  input  logic            stall_w_i_h,
  input  logic            flush_w_i_h,
  output logic            hazard_stall_w_o_h,
  output logic            ex_valid_w_o_h,
  output logic [XLEN-1:0] a_data_w_o,
  output logic [XLEN-1:0] b_data_w_o,
  output logic [3:0]      alu_control_w_o,
  output logic [XLEN-1:0] store_data_w_o,
  output logic [XLEN-1:0] imm_w_o,
  output logic [XLEN-1:0] pc_w_o,
  output logic [4:0]      rd_w_o,
  output logic            rd_wen_w_o_h,
  output logic            is_load_w_o_h,
  output logic            is_store_w_o_h,
  output logic            is_branch_w_o_h,
  output logic            is_jump_w_o_h,
  output logic [2:0]      funct3_w_o,
  output logic            illegal_w_o_h
);

  decode_t         dec;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;

  assign rs1 = instr_w_i[19:15];
  assign rs2 = instr_w_i[24:20];

  rv32_decoder u_decoder (
    .instr (instr_w_i),
    .dec   (dec)
  );

  // Operand forwarding: youngest producer (EX/MEM) wins; x0 is never forwarded.
  always_comb begin
    rs1_fwd = rs1_data_w_i;
    rs2_fwd = rs2_data_w_i;
    if (rs1 != 5'd0) begin
      if (exmem_wen_w_i_h && exmem_rd_w_i == rs1)      rs1_fwd = exmem_data_w_i;
      else if (memwb_wen_w_i_h && memwb_rd_w_i == rs1) rs1_fwd = memwb_data_w_i;
    end
    if (rs2 != 5'd0) begin
      if (exmem_wen_w_i_h && exmem_rd_w_i == rs2)      rs2_fwd = exmem_data_w_i;
      else if (memwb_wen_w_i_h && memwb_rd_w_i == rs2) rs2_fwd = memwb_data_w_i;
    end
  end

  // ALU operand selection from the decoder's A/B selects.
  always_comb begin
    a_next = '0;
    b_next = '0;
    case (dec.a_sel)
      A_RS1:   a_next = rs1_fwd;
      A_PC:    a_next = pc_w_i;
      default: a_next = '0;
    endcase
    case (dec.b_sel)
      B_RS2:   b_next = rs2_fwd;
      B_IMM:   b_next = dec.imm;
      B_SHAMT: b_next = {27'd0, dec.imm[4:0]};
      B_FOUR:  b_next = 32'd4;
      default: b_next = '0;
    endcase
  end

  // A load in EX cannot forward its data yet; stall a consumer sitting in decode.
  assign hazard_stall_w_o_h = valid_w_i_h & ex_valid_w_o_h & is_load_w_o_h & (rd_w_o != 5'd0) &
                              ((dec.rs1_used & (rd_w_o == rs1)) | (dec.rs2_used & (rd_w_o == rs2)));

  // Stage register: reset > flush > stall (hold) > hazard bubble > load.
  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      ex_valid_w_o_h  <= 1'b0;
      a_data_w_o      <= '0;
      b_data_w_o      <= '0;
      alu_control_w_o <= ALU_ADD;
      store_data_w_o  <= '0;
      imm_w_o         <= '0;
      pc_w_o          <= RESET_PC;
      rd_w_o          <= '0;
      rd_wen_w_o_h    <= 1'b0;
      is_load_w_o_h   <= 1'b0;
      is_store_w_o_h  <= 1'b0;
      is_branch_w_o_h <= 1'b0;
      is_jump_w_o_h   <= 1'b0;
      funct3_w_o      <= '0;
      illegal_w_o_h   <= 1'b0;
    end else if (flush_w_i_h || (!stall_w_i_h && hazard_stall_w_o_h)) begin
      ex_valid_w_o_h  <= 1'b0;
      rd_wen_w_o_h    <= 1'b0;
      is_load_w_o_h   <= 1'b0;
      is_store_w_o_h  <= 1'b0;
      is_branch_w_o_h <= 1'b0;
      is_jump_w_o_h   <= 1'b0;
      illegal_w_o_h   <= 1'b0;
    end else if (!stall_w_i_h) begin
      ex_valid_w_o_h  <= valid_w_i_h;
      a_data_w_o      <= a_next;
      b_data_w_o      <= b_next;
      alu_control_w_o <= dec.alu_ctrl;
      store_data_w_o  <= rs2_fwd;
      imm_w_o         <= dec.imm;
      pc_w_o          <= pc_w_i;
      rd_w_o          <= instr_w_i[11:7];
      rd_wen_w_o_h    <= valid_w_i_h & dec.rd_wen;
      is_load_w_o_h   <= valid_w_i_h & dec.is_load;
      is_store_w_o_h  <= valid_w_i_h & dec.is_store;
      is_branch_w_o_h <= valid_w_i_h & dec.is_branch;
      is_jump_w_o_h   <= valid_w_i_h & dec.is_jump;
      funct3_w_o      <= instr_w_i[14:12];
      illegal_w_o_h   <= valid_w_i_h & dec.illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hazard/flush/stall/
// reset sequences, then random stimulus against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, valid, stall, flush;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_wen, memwb_wen;
  logic [31:0] exmem_data, memwb_data;
  logic        hazard, ex_valid, rd_wen, is_load, is_store, is_branch, is_jump, illegal;
  logic [31:0] a_data, b_data, store_data, imm, pc_o;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic [2:0]  funct3;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_w_i(clk), .rst_w_i_h(rst), .valid_w_i_h(valid), .instr_w_i(instr), .pc_w_i(pc),
    .rs1_data_w_i(rs1_data), .rs2_data_w_i(rs2_data),
    .exmem_rd_w_i(exmem_rd), .exmem_wen_w_i_h(exmem_wen), .exmem_data_w_i(exmem_data),
    .memwb_rd_w_i(memwb_rd), .memwb_wen_w_i_h(memwb_wen), .memwb_data_w_i(memwb_data),
    .stall_w_i_h(stall), .flush_w_i_h(flush), .hazard_stall_w_o_h(hazard),
    .ex_valid_w_o_h(ex_valid), .a_data_w_o(a_data), .b_data_w_o(b_data),
    .alu_control_w_o(alu_control), .store_data_w_o(store_data), .imm_w_o(imm),
    .pc_w_o(pc_o), .rd_w_o(rd), .rd_wen_w_o_h(rd_wen), .is_load_w_o_h(is_load),
    .is_store_w_o_h(is_store), .is_branch_w_o_h(is_branch), .is_jump_w_o_h(is_jump),
    .funct3_w_o(funct3), .illegal_w_o_h(illegal)
  );

  // expected EX-slot contents
  typedef struct {
    logic [31:0] a, b, store, imm, pc;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        valid, wen, ld, st, br, jp, ill;
  } ex_t;

  typedef struct {
    logic [31:0] instr, pc, rs1d, rs2d;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic [31:0] ex_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;
    logic [31:0] a, b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        wen, ill;
  } vec_t;

  ex_t  m;
  ex_t  reset_val;
  vec_t vt[13];

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: register value a read of rs sees after forwarding
  function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (exmem_wen && exmem_rd == rs) return exmem_data;
    if (memwb_wen && memwb_rd == rs) return memwb_data;
    return rf;
  endfunction

  // model: what the current decode slot should become in EX
  function automatic ex_t decode_ref();
    ex_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] ii, si, bi, ui, ji, r1, r2;
    logic        writes;
    op = instr[6:0];
    f3 = instr[14:12];
    ii = 32'($signed(instr[31:20]));
    si = 32'($signed({instr[31:25], instr[11:7]}));
    bi = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    ji = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    ui = {instr[31:12], 12'h000};
    r1 = fwd_ref(instr[19:15], rs1_data);
    r2 = fwd_ref(instr[24:20], rs2_data);
    e = reset_val;
    e.valid = valid; e.pc = pc; e.rd = instr[11:7]; e.f3 = f3; e.store = r2;
    writes = 1'b1;
    case (op)
      7'h33: begin e.a = r1; e.b = r2; e.ctrl = {instr[30] && (f3 == 0 || f3 == 5), f3}; end
      7'h13: begin
        e.a = r1; e.imm = ii; e.b = (f3 == 1 || f3 == 5) ? (ii % 32) : ii;
        e.ctrl = {instr[30] && f3 == 5, f3};
      end
      7'h37: begin e.a = 0;  e.b = ui; e.imm = ui; end
      7'h17: begin e.a = pc; e.b = ui; e.imm = ui; end
      7'h6F: begin e.a = pc; e.b = 4;  e.imm = ji; e.jp = 1; end
      7'h67: begin e.a = pc; e.b = 4;  e.imm = ii; e.jp = 1; end
      7'h03: begin e.a = r1; e.b = ii; e.imm = ii; e.ld = 1; end
      7'h23: begin e.a = r1; e.b = si; e.imm = si; e.st = 1; writes = 0; end
      7'h63: begin e.a = r1; e.b = r2; e.imm = bi; e.br = 1; e.ctrl = 4'd8; writes = 0; end
      default: begin e.a = 0; e.b = 0; e.imm = 0; e.ill = 1; writes = 0; end
    endcase
    e.wen = writes && e.rd != 0;
    if (!valid) begin
      e.valid = 0; e.wen = 0; e.ld = 0; e.st = 0; e.br = 0; e.jp = 0; e.ill = 0;
    end
    return e;
  endfunction

  function automatic logic hazard_ref();
    logic [6:0] op;
    logic       use1, use2;
    op   = instr[6:0];
    use1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    use2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return valid && m.valid && m.ld && m.rd != 0 &&
           ((use1 && m.rd == instr[19:15]) || (use2 && m.rd == instr[24:20]));
  endfunction

  function automatic ex_t bubble_of(input ex_t s);
    ex_t r;
    r = s;
    r.valid = 0; r.wen = 0; r.ld = 0; r.st = 0; r.br = 0; r.jp = 0; r.ill = 0;
    return r;
  endfunction

  function automatic ex_t next_ref();
    if (rst)          return reset_val;
    if (flush)        return bubble_of(m);
    if (stall)        return m;
    if (hazard_ref()) return bubble_of(m);
    return decode_ref();
  endfunction

  // driver: advance one clock, updating the model, and land on the next falling edge
  task automatic step();
    ex_t nxt;
    nxt = next_ref();
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    valid = 0; stall = 0; flush = 0; instr = 32'h0000_0013; pc = 0;
    rs1_data = 0; rs2_data = 0; exmem_rd = 0; exmem_wen = 0; exmem_data = 0;
    memwb_rd = 0; memwb_wen = 0; memwb_data = 0;
  endtask

  task automatic drive_valid(input logic [31:0] i, input logic [31:0] p,
                             input logic [31:0] r1, input logic [31:0] r2);
    valid = 1; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  // compare control always, datapath only when the slot holds a real instruction
  task automatic compare_model(input string tag);
    chk({tag, ".valid"}, ex_valid, m.valid);
    chk({tag, ".wen"},   rd_wen,   m.wen);
    chk({tag, ".flags"}, {is_load, is_store, is_branch, is_jump, illegal},
                         {m.ld, m.st, m.br, m.jp, m.ill});
    if (m.valid) begin
      chk({tag, ".a"},     a_data,      m.a);
      chk({tag, ".b"},     b_data,      m.b);
      chk({tag, ".ctrl"},  alu_control, m.ctrl);
      chk({tag, ".store"}, store_data,  m.store);
      chk({tag, ".imm"},   imm,         m.imm);
      chk({tag, ".pc"},    pc_o,        m.pc);
      chk({tag, ".rd"},    rd,          m.rd);
      chk({tag, ".f3"},    funct3,      m.f3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ctl"}, {ex_valid, rd_wen, is_load, is_store, is_branch, is_jump, illegal}, 0);
    chk({tag, ".ab"},  a_data | b_data | store_data | imm, 0);
    chk({tag, ".ctrl_rd_f3"}, {alu_control, rd, funct3}, 0);
    chk({tag, ".pc"}, pc_o, 32'h0000_0000);
  endtask

  initial begin
    logic [6:0] ops[10];
    reset_val = '{default: 0};
    m = reset_val;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F};

    //         instr          pc           rs1d         rs2d     exrd wen exdata      wbrd wen wbdata      a             b             ctrl  rd wen ill
    vt[0]  = '{32'h002081B3, 32'h0,       32'd5,       32'd7,     0, 0, 32'h0,        0, 0, 32'h0,       32'd5,        32'd7,        4'h0, 3, 1, 0}; // ADD x3,x1,x2
    vt[1]  = '{32'h4030D213, 32'h0,       32'h80000000,32'd0,     0, 0, 32'h0,        0, 0, 32'h0,       32'h80000000, 32'd3,        4'hD, 4, 1, 0}; // SRAI x4,x1,3
    vt[2]  = '{32'h402082B3, 32'h4,       32'd10,      32'd3,     0, 0, 32'h0,        0, 0, 32'h0,       32'd10,       32'd3,        4'h8, 5, 1, 0}; // SUB x5,x1,x2
    vt[3]  = '{32'h002280B3, 32'h8,       32'h1111,    32'h22,    5, 1, 32'hAAAA,     5, 1, 32'hBBBB,    32'hAAAA,     32'h22,       4'h0, 1, 1, 0}; // EX/MEM beats MEM/WB
    vt[4]  = '{32'h002280B3, 32'h8,       32'h1111,    32'h22,    0, 1, 32'hAAAA,     0, 1, 32'hBBBB,    32'h1111,     32'h22,       4'h0, 1, 1, 0}; // producers write x0
    vt[5]  = '{32'h002000B3, 32'hC,       32'h0,       32'h22,    0, 1, 32'hAAAA,     0, 1, 32'hBBBB,    32'h0,        32'h22,       4'h0, 1, 1, 0}; // rs1=x0 never forwarded
    vt[6]  = '{32'h002280B3, 32'h8,       32'h1111,    32'h22,    6, 1, 32'hAAAA,     5, 1, 32'hBBBB,    32'hBBBB,     32'h22,       4'h0, 1, 1, 0}; // MEM/WB only
    vt[7]  = '{32'h12345437, 32'h10,      32'h99,      32'h0,     0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        32'h12345000, 4'h0, 8, 1, 0}; // LUI
    vt[8]  = '{32'hFFFFF497, 32'h100,     32'h99,      32'h0,     0, 0, 32'h0,        0, 0, 32'h0,       32'h100,      32'hFFFFF000, 4'h0, 9, 1, 0}; // AUIPC
    vt[9]  = '{32'h008000EF, 32'h200,     32'h99,      32'h0,     0, 0, 32'h0,        0, 0, 32'h0,       32'h200,      32'd4,        4'h0, 1, 1, 0}; // JAL x1
    vt[10] = '{32'h00208463, 32'h300,     32'd40,      32'd41,    0, 0, 32'h0,        0, 0, 32'h0,       32'd40,       32'd41,       4'h8, 8, 0, 0}; // BEQ
    vt[11] = '{32'h0020A223, 32'h304,     32'h1000,    32'h5,     0, 0, 32'h0,        0, 0, 32'h0,       32'h1000,     32'd4,        4'h0, 4, 0, 0}; // SW
    vt[12] = '{32'hFFF13093, 32'h308,     32'd77,      32'd0,     0, 0, 32'h0,        0, 0, 32'h0,       32'd77,       32'hFFFFFFFF, 4'h3, 1, 1, 0}; // SLTIU -1

    // reset
    drive_idle();
    rst = 1;
    @(negedge clk);
    step();
    step();
    check_reset_outputs("reset");
    rst = 0;

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      drive_valid(vt[i].instr, vt[i].pc, vt[i].rs1d, vt[i].rs2d);
      exmem_rd = vt[i].ex_rd; exmem_wen = vt[i].ex_wen; exmem_data = vt[i].ex_data;
      memwb_rd = vt[i].wb_rd; memwb_wen = vt[i].wb_wen; memwb_data = vt[i].wb_data;
      step();
      chk($sformatf("vec%0d.valid", i), ex_valid, 1);
      chk($sformatf("vec%0d.a", i), a_data, vt[i].a);
      chk($sformatf("vec%0d.b", i), b_data, vt[i].b);
      chk($sformatf("vec%0d.ctrl", i), alu_control, vt[i].ctrl);
      chk($sformatf("vec%0d.rd", i), rd, vt[i].rd);
      chk($sformatf("vec%0d.wen_ill", i), {rd_wen, illegal}, {vt[i].wen, vt[i].ill});
    end

    // illegal opcode
    drive_idle();
    drive_valid(32'h0000007F, 32'h400, 32'h1, 32'h2);
    step();
    chk("illegal.flag", illegal, 1);
    chk("illegal.wen_flags", {rd_wen, is_load, is_store, is_branch, is_jump}, 0);
    chk("illegal.ctrl", alu_control, 4'h0);

    // load-use: LW x6 then ADD x7,x6,x1
    drive_valid(32'h0000A303, 32'h500, 32'h100, 32'h0);
    step();
    chk("lw.is_load", {ex_valid, is_load, rd}, {1'b1, 1'b1, 5'd6});
    drive_valid(32'h001303B3, 32'h504, 32'h1234, 32'h10);
    #1 chk("lu.hazard_on", hazard, 1);
    step();
    chk("lu.bubble", {ex_valid, rd_wen}, 0);
    memwb_rd = 6; memwb_wen = 1; memwb_data = 32'hDEADBEEF;
    #1 chk("lu.hazard_off", hazard, 0);
    step();
    chk("lu.issue", {ex_valid, rd}, {1'b1, 5'd7});
    chk("lu.a_fwd", a_data, 32'hDEADBEEF);
    chk("lu.b", b_data, 32'h10);

    // hazard held while externally stalled
    drive_idle();
    drive_valid(32'h0000A303, 32'h600, 32'h100, 32'h0);
    step();
    drive_valid(32'h001303B3, 32'h604, 32'h1, 32'h2);
    stall = 1;
    #1 chk("lus.hazard", hazard, 1);
    step();
    #1 chk("lus.hazard_held", hazard, 1);
    chk("lus.load_held", {ex_valid, is_load}, 2'b11);
    stall = 0;
    step();
    chk("lus.bubble", ex_valid, 0);
    #1 chk("lus.hazard_clear", hazard, 0);

    // stall holds a valid instruction
    drive_idle();
    drive_valid(32'h002081B3, 32'h700, 32'd5, 32'd7);
    step();
    drive_valid(32'h402082B3, 32'h704, 32'd50, 32'd1);
    stall = 1;
    step();
    chk("stall.hold_a", a_data, 32'd5);
    chk("stall.hold_ctl", {ex_valid, alu_control, rd}, {1'b1, 4'h0, 5'd3});

    // flush wins over stall
    flush = 1;
    step();
    chk("flush.valid_wen", {ex_valid, rd_wen}, 0);
    flush = 0;

    // reset during stall
    drive_valid(32'h002081B3, 32'h800, 32'd5, 32'd7);
    step();
    stall = 1; rst = 1;
    step();
    check_reset_outputs("rst_stall");
    rst = 0; stall = 0;

    // random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      instr = $urandom;
      instr[6:0]   = ops[$urandom_range(0, 9)];
      instr[11:7]  = 5'($urandom_range(0, 7));
      instr[19:15] = 5'($urandom_range(0, 7));
      instr[24:20] = 5'($urandom_range(0, 7));
      valid      = ($urandom_range(0, 99) < 85);
      stall      = ($urandom_range(0, 99) < 10);
      flush      = ($urandom_range(0, 99) < 5);
      pc         = $urandom & 32'hFFFF_FFFC;
      rs1_data   = $urandom;
      rs2_data   = $urandom;
      exmem_rd   = 5'($urandom_range(0, 7));
      exmem_wen  = 1'($urandom_range(0, 1));
      exmem_data = $urandom;
      memwb_rd   = 5'($urandom_range(0, 7));
      memwb_wen  = 1'($urandom_range(0, 1));
      memwb_data = $urandom;
      #1 chk("rand.hazard", hazard, hazard_ref());
      step();
      compare_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
